// File: rtl/rtp_pkg.sv
// Shared types and helpers for the ray-traversal processor: FSM states,
// word width, the "no hit" triangle marker and the leaf test.
package rtp_pkg;

  localparam int WORD_W = 32;
  localparam logic [15:0] NO_HIT = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE,
    RAY_RD,
    RAY_INIT,
    POP,
    NODE_RD,
    NODE_EVAL,
    TRI_RD,
    TRI_EVAL,
    RAY_DONE,
    FINISH
  } state_t;

  // A node carries triangles exactly when its triangle count is non-zero.
  function automatic logic is_leaf(input logic [WORD_W-1:0] node_w);
    return node_w != '0;
  endfunction

endpackage

// File: rtl/rom_1r.sv
// Read-only memory with one synchronous read port; contents are preloaded
// from outside through the array named mem.
module rom_1r #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    rdata <= mem[addr];
  end

endmodule

// File: rtl/trav_stack.sv
// Traversal LIFO. A cycle may clear, pop, then push one or two entries
// (push_data lands first, push2_data ends on top). Pushes past full are dropped.
module trav_stack #(
  parameter int DEPTH = 32,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         pop,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push2,
  input  logic [W-1:0] push2_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  entries [DEPTH];
  logic [CW-1:0] cnt, cnt_m1, base, mid, cnt_nxt;
  logic          wr0, wr1;

  always_comb begin
    base    = clear ? '0 : ((pop && cnt != '0) ? cnt - 1'b1 : cnt);
    wr0     = push && (base < CW'(DEPTH));
    mid     = base + CW'(wr0);
    wr1     = push2 && (mid < CW'(DEPTH));
    cnt_nxt = mid + CW'(wr1);
    cnt_m1  = cnt - 1'b1;
  end

  assign top_data = entries[cnt_m1[AW-1:0]];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (wr0) entries[base[AW-1:0]] <= push_data;
      if (wr1) entries[mid[AW-1:0]]  <= push2_data;
      if ((push && !wr0) || (push2 && !wr1)) $error("trav_stack: push dropped, stack full");
    end
  end

endmodule

// File: rtl/rtp_top.sv
// Ray-traversal processor: walks each ray through the BVH with an explicit
// stack, plane-tests leaf triangles and reports the closest hit per ray.
module rtp_top
  import rtp_pkg::*;
#(
  parameter int NUM_RAYS    = 16,
  parameter int NODE_AW     = 8,
  parameter int TRI_AW      = 10,
  parameter int STACK_DEPTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_hitT,
  output logic [31:0] io_ray_id_triangle,
  output logic        io_rtp_finish,
  output logic [63:0] io_counter_fdiv,
  output logic [3:0]  dbg_state
);

  localparam int RAY_AW = (NUM_RAYS > 1) ? $clog2(NUM_RAYS) : 1;

  state_t state, state_nxt;

  logic [15:0]              ray_id;
  logic signed [WORD_W-1:0] ox, oy, oz, hit_t, tri_t;
  logic [15:0]              hit_tri;
  logic [NODE_AW-1:0]       n_c0, n_c1;
  logic [WORD_W-1:0]        n_ts, n_tc, tri_idx, tri_left;
  logic                     tri_hit, more_rays;

  logic [WORD_W-1:0] ray_ox_q, ray_oy_q, ray_oz_q, ray_hitT_q;
  logic [WORD_W-1:0] node_x_q, node_y_q, node_z_q, node_w_q;
  logic [WORD_W-1:0] tri_x_q, tri_y_q, tri_z_q, tri_w_q;

  logic               stk_clear, stk_pop, stk_push, stk_push2;
  logic [NODE_AW-1:0] stk_push_data, stk_top;
  logic               stk_empty, stk_full;
  logic               unused_bits;

  rom_1r #(.AW(RAY_AW), .DW(WORD_W)) ray_ox   (.clock(clock), .addr(ray_id[RAY_AW-1:0]), .rdata(ray_ox_q));
  rom_1r #(.AW(RAY_AW), .DW(WORD_W)) ray_oy   (.clock(clock), .addr(ray_id[RAY_AW-1:0]), .rdata(ray_oy_q));
  rom_1r #(.AW(RAY_AW), .DW(WORD_W)) ray_oz   (.clock(clock), .addr(ray_id[RAY_AW-1:0]), .rdata(ray_oz_q));
  rom_1r #(.AW(RAY_AW), .DW(WORD_W)) ray_hitT (.clock(clock), .addr(ray_id[RAY_AW-1:0]), .rdata(ray_hitT_q));

  rom_1r #(.AW(NODE_AW), .DW(WORD_W)) node_x (.clock(clock), .addr(stk_top), .rdata(node_x_q));
  rom_1r #(.AW(NODE_AW), .DW(WORD_W)) node_y (.clock(clock), .addr(stk_top), .rdata(node_y_q));
  rom_1r #(.AW(NODE_AW), .DW(WORD_W)) node_z (.clock(clock), .addr(stk_top), .rdata(node_z_q));
  rom_1r #(.AW(NODE_AW), .DW(WORD_W)) node_w (.clock(clock), .addr(stk_top), .rdata(node_w_q));

  rom_1r #(.AW(TRI_AW), .DW(WORD_W)) tri_x (.clock(clock), .addr(tri_idx[TRI_AW-1:0]), .rdata(tri_x_q));
  rom_1r #(.AW(TRI_AW), .DW(WORD_W)) tri_y (.clock(clock), .addr(tri_idx[TRI_AW-1:0]), .rdata(tri_y_q));
  rom_1r #(.AW(TRI_AW), .DW(WORD_W)) tri_z (.clock(clock), .addr(tri_idx[TRI_AW-1:0]), .rdata(tri_z_q));
  rom_1r #(.AW(TRI_AW), .DW(WORD_W)) tri_w (.clock(clock), .addr(tri_idx[TRI_AW-1:0]), .rdata(tri_w_q));

  trav_stack #(.DEPTH(STACK_DEPTH), .W(NODE_AW)) u_stack (
    .clock(clock), .reset(reset), .clear(stk_clear), .pop(stk_pop),
    .push(stk_push), .push_data(stk_push_data),
    .push2(stk_push2), .push2_data(n_c0),
    .top_data(stk_top), .empty(stk_empty), .full(stk_full)
  );

  // Plane distance; products wrap to the low 32 bits.
  assign tri_t = $signed(tri_w_q)
               - ($signed(tri_x_q) * ox + $signed(tri_y_q) * oy + $signed(tri_z_q) * oz);
  assign tri_hit   = (tri_t > 32'sd0) && (tri_t < hit_t);
  assign more_rays = ({16'd0, ray_id} + 32'd1) < NUM_RAYS;
  assign dbg_state = state;

  assign unused_bits = ^{node_x_q[WORD_W-1:NODE_AW], node_y_q[WORD_W-1:NODE_AW],
                         tri_idx[WORD_W-1:16], stk_full};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    stk_clear     = 1'b0;
    stk_pop       = 1'b0;
    stk_push      = 1'b0;
    stk_push2     = 1'b0;
    stk_push_data = n_c1;
    case (state)
      IDLE:     state_nxt = RAY_RD;
      RAY_RD:   state_nxt = RAY_INIT;
      RAY_INIT: begin
        stk_clear     = 1'b1;
        stk_push      = 1'b1;
        stk_push_data = '0;
        state_nxt     = POP;
      end
      POP: begin
        stk_pop   = !stk_empty;
        state_nxt = stk_empty ? RAY_DONE : NODE_RD;
      end
      NODE_RD:  state_nxt = NODE_EVAL;
      NODE_EVAL: begin
        if (is_leaf(n_tc)) begin
          state_nxt = TRI_RD;
        end else begin
          // child1 goes in first so child0 sits on top and is visited next
          stk_push  = 1'b1;
          stk_push2 = 1'b1;
          state_nxt = POP;
        end
      end
      TRI_RD:   state_nxt = TRI_EVAL;
      TRI_EVAL: begin
        if (tri_left == 32'd1) state_nxt = stk_empty ? RAY_DONE : POP;
        else                   state_nxt = TRI_RD;
      end
      RAY_DONE: state_nxt = more_rays ? RAY_RD : FINISH;
      FINISH:   state_nxt = FINISH;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ray_id             <= '0;
      ox                 <= '0;
      oy                 <= '0;
      oz                 <= '0;
      hit_t              <= '0;
      hit_tri            <= NO_HIT;
      n_c0               <= '0;
      n_c1               <= '0;
      n_ts               <= '0;
      n_tc               <= '0;
      tri_idx            <= '0;
      tri_left           <= '0;
      io_hitT            <= '0;
      io_ray_id_triangle <= '0;
      io_rtp_finish      <= 1'b0;
      io_counter_fdiv    <= '0;
    end else begin
      case (state)
        RAY_INIT: begin
          ox      <= $signed(ray_ox_q);
          oy      <= $signed(ray_oy_q);
          oz      <= $signed(ray_oz_q);
          hit_t   <= $signed(ray_hitT_q);
          hit_tri <= NO_HIT;
        end
        NODE_RD: begin
          n_c0 <= node_x_q[NODE_AW-1:0];
          n_c1 <= node_y_q[NODE_AW-1:0];
          n_ts <= node_z_q;
          n_tc <= node_w_q;
        end
        NODE_EVAL: begin
          if (is_leaf(n_tc)) begin
            tri_idx  <= n_ts;
            tri_left <= n_tc;
          end
        end
        TRI_EVAL: begin
          io_counter_fdiv <= io_counter_fdiv + 64'd1;
          tri_idx         <= tri_idx + 32'd1;
          tri_left        <= tri_left - 32'd1;
          if (tri_hit) begin
            hit_t   <= tri_t;
            hit_tri <= tri_idx[15:0];
          end
        end
        RAY_DONE: begin
          io_hitT            <= hit_t;
          io_ray_id_triangle <= {ray_id, hit_tri};
          if (more_rays) ray_id <= ray_id + 16'd1;
          else           io_rtp_finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtp_top.sv
// Bench for rtp_top: preloads small scenes, predicts per-ray results with a
// reference traversal, and scores each completed ray against a queue.
module tb_rtp_top;
  import rtp_pkg::*;

  localparam int NR = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_hitT, io_ray_id_triangle;
  logic        io_rtp_finish;
  logic [63:0] io_counter_fdiv;
  logic [3:0]  dbg_state;

  rtp_top #(.NUM_RAYS(NR), .NODE_AW(8), .TRI_AW(10), .STACK_DEPTH(32)) dut (
    .clock(clock), .reset(reset), .io_hitT(io_hitT),
    .io_ray_id_triangle(io_ray_id_triangle), .io_rtp_finish(io_rtp_finish),
    .io_counter_fdiv(io_counter_fdiv), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_total;
  int          done_cnt, fin_rises;
  logic [3:0]  prev_state = 4'd0;
  logic        prev_fin = 1'b0;

  logic [31:0] nx [256], ny [256], nz [256], nw [256];
  logic [31:0] tx [1024], ty [1024], tz [1024], tw [1024];
  logic [31:0] rox [NR], roy [NR], roz [NR], rht [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: each cycle after RAY_DONE the status outputs hold that ray's result.
  always @(negedge clock) begin
    if (prev_state == RAY_DONE) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ray", {io_hitT, io_ray_id_triangle}, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("hitT", {32'd0, io_hitT}, {32'd0, e[63:32]});
        check("ray_id_tri", {32'd0, io_ray_id_triangle}, {32'd0, e[31:0]});
      end
      check("finish_at_done", {63'd0, io_rtp_finish}, {63'd0, done_cnt == NR});
    end
    if (io_rtp_finish && !prev_fin) fin_rises++;
    prev_fin   = io_rtp_finish;
    prev_state = dbg_state;
  end

  task automatic clear_scene();
    for (int i = 0; i < 256; i++) begin
      nx[i] = 0; ny[i] = 0; nz[i] = 0; nw[i] = 0;
    end
    for (int i = 0; i < 1024; i++) begin
      tx[i] = 0; ty[i] = 0; tz[i] = 0; tw[i] = 0;
    end
  endtask

  task automatic set_node(input int n, input int c0, input int c1, input int ts, input int tc);
    nx[n] = c0; ny[n] = c1; nz[n] = ts; nw[n] = tc;
  endtask

  task automatic set_tri(input int i, input int x, input int y, input int z, input int w);
    tx[i] = x; ty[i] = y; tz[i] = z; tw[i] = w;
  endtask

  task automatic set_ray(input int r, input int x, input int y, input int z, input int h);
    rox[r] = x; roy[r] = y; roz[r] = z; rht[r] = h;
  endtask

  task automatic load_dut();
    for (int i = 0; i < 256; i++) begin
      dut.node_x.mem[i] = nx[i]; dut.node_y.mem[i] = ny[i];
      dut.node_z.mem[i] = nz[i]; dut.node_w.mem[i] = nw[i];
    end
    for (int i = 0; i < 1024; i++) begin
      dut.tri_x.mem[i] = tx[i]; dut.tri_y.mem[i] = ty[i];
      dut.tri_z.mem[i] = tz[i]; dut.tri_w.mem[i] = tw[i];
    end
    for (int r = 0; r < NR; r++) begin
      dut.ray_ox.mem[r] = rox[r]; dut.ray_oy.mem[r] = roy[r];
      dut.ray_oz.mem[r] = roz[r]; dut.ray_hitT.mem[r] = rht[r];
    end
  endtask

  // Reference traversal: depth-first, child0 before child1, strict closest hit.
  task automatic model_ray(input int r, output logic [31:0] ht, output logic [15:0] tri_o,
                           output int tests);
    int stk[$];
    int n, guard;
    logic signed [31:0] t, best;
    stk.push_back(0);
    best  = $signed(rht[r]);
    tri_o = 16'hFFFF;
    tests = 0;
    guard = 0;
    while (stk.size() > 0 && guard < 1000) begin
      guard++;
      n = stk.pop_back();
      if (nw[n] != 0) begin
        for (int k = 0; k < int'(nw[n]); k++) begin
          int idx;
          idx = int'(nz[n]) + k;
          t = $signed(tw[idx]) - ($signed(rox[r]) * $signed(tx[idx])
                                + $signed(roy[r]) * $signed(ty[idx])
                                + $signed(roz[r]) * $signed(tz[idx]));
          tests++;
          if (t > 0 && t < best) begin
            best  = t;
            tri_o = idx[15:0];
          end
        end
      end else begin
        stk.push_back(int'(ny[n] & 32'hFF));
        stk.push_back(int'(nx[n] & 32'hFF));
      end
    end
    ht = best;
  endtask

  task automatic build_expect();
    logic [31:0] ht;
    logic [15:0] tri_o;
    int tests;
    exp_q.delete();
    exp_total = 0;
    done_cnt  = 0;
    fin_rises = 0;
    for (int r = 0; r < NR; r++) begin
      model_ray(r, ht, tri_o, tests);
      exp_q.push_back({ht, r[15:0], tri_o});
      exp_total += 64'(tests);
    end
  endtask

  task automatic run_scene(input string name, input bit mid_reset);
    reset = 1'b1;
    repeat (2) cyc();
    check({name, "_reset_hitT"}, {32'd0, io_hitT}, 64'd0);
    check({name, "_reset_cnt"}, io_counter_fdiv, 64'd0);
    load_dut();
    build_expect();
    reset = 1'b0;
    if (mid_reset) begin
      for (int k = 0; k < 2000 && done_cnt < 1; k++) cyc();
      check({name, "_first_ray_seen"}, 64'(done_cnt >= 1), 64'd1);
      repeat (3) cyc();
      reset = 1'b1;
      cyc();
      check({name, "_mid_hitT"}, {32'd0, io_hitT}, 64'd0);
      check({name, "_mid_idtri"}, {32'd0, io_ray_id_triangle}, 64'd0);
      check({name, "_mid_finish"}, {63'd0, io_rtp_finish}, 64'd0);
      check({name, "_mid_cnt"}, io_counter_fdiv, 64'd0);
      check({name, "_mid_state"}, {60'd0, dbg_state}, {60'd0, IDLE});
      build_expect();
      reset = 1'b0;
    end
    for (int k = 0; k < 5000 && !io_rtp_finish; k++) cyc();
    check({name, "_finish"}, {63'd0, io_rtp_finish}, 64'd1);
    repeat (4) cyc();
    check({name, "_counter"}, io_counter_fdiv, exp_total);
    check({name, "_rays_done"}, 64'(done_cnt), 64'(NR));
    check({name, "_fin_rises"}, 64'(fin_rises), 64'd1);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_state_final"}, {60'd0, dbg_state}, {60'd0, FINISH});
  endtask

  initial begin
    // A: root leaf with two triangles, t = 50 then 30
    clear_scene();
    set_node(0, 0, 0, 0, 2);
    set_tri(0, 0, 0, 0, 50);
    set_tri(1, 0, 0, 0, 30);
    set_ray(0, 0, 0, 0, 100);
    set_ray(1, 1, 0, 0, 40);
    set_ray(2, 0, 0, 0, 30);
    set_ray(3, 0, 0, 0, 20);
    run_scene("leaf2", 1'b0);

    // B: single triangle (1,1,1,10) against several origins
    clear_scene();
    set_node(0, 0, 0, 0, 1);
    set_tri(0, 1, 1, 1, 10);
    set_ray(0, 1, 2, 3, 100);
    set_ray(1, 0, 0, 0, 100);
    set_ray(2, 5, 5, 5, 100);
    set_ray(3, 1, 2, 3, 4);
    run_scene("plane", 1'b0);

    // C: negative, equal-to-hitT and zero t
    clear_scene();
    set_node(0, 0, 0, 3, 3);
    set_tri(3, 0, 0, 0, -5);
    set_tri(4, 0, 0, 0, 20);
    set_tri(5, 0, 0, 0, 0);
    set_ray(0, 0, 0, 0, 20);
    set_ray(1, 7, -2, 4, 20);
    set_ray(2, 0, 0, 0, 20);
    set_ray(3, 0, 0, 0, 21);
    run_scene("edge_t", 1'b0);

    // D: inner root, node 1 visited first; equal t keeps node 1's triangle
    clear_scene();
    set_node(0, 1, 2, 0, 0);
    set_node(1, 0, 0, 0, 1);
    set_node(2, 0, 0, 1, 1);
    set_tri(0, 1, 0, 0, 8);
    set_tri(1, 0, 0, 0, 6);
    set_ray(0, 0, 0, 0, 100);
    set_ray(1, 2, 0, 0, 100);
    set_ray(2, 1, 0, 0, 100);
    set_ray(3, 0, 0, 0, 7);
    run_scene("inner", 1'b0);

    // E: random two-level tree with a reset during the second ray
    clear_scene();
    set_node(0, 1, 2, 0, 0);
    set_node(1, 3, 4, 0, 0);
    set_node(2, 0, 0, 0, 3);
    set_node(3, 0, 0, 3, 2);
    set_node(4, 0, 0, 5, 3);
    for (int i = 0; i < 8; i++)
      set_tri(i, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
              int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 200)) - 50);
    set_ray(0, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
            int'($urandom_range(0, 6)) - 3, 1000);
    for (int r = 1; r < NR; r++)
      set_ray(r, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
              int'($urandom_range(0, 6)) - 3, int'($urandom_range(20, 150)));
    run_scene("rand_reset", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
